// File: rtl/svm_pkg.sv
// Shared types and constants for the SVM pixel memory responder.
package svm_pkg;

    localparam int XLEN_PIXEL_DEF = 8;

    typedef enum logic [1:0] {
        LOAD,
        FULL,
        STREAM,
        DONE
    } state_t;

    // Index width for a count of n items; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/svm_pixel_ram.sv
// Single-port synchronous RAM with a registered read port.
// The read register only updates when en is high, so a stalled reader keeps its data.
module svm_pixel_ram
    import svm_pkg::*;
#(
    parameter  int WIDTH = XLEN_PIXEL_DEF,
    parameter  int DEPTH = 784,
    localparam int AW    = idx_w(DEPTH)
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset; clearing it would turn the RAM into flops.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (en) rdata <= mem[addr];
    end

endmodule

// File: rtl/svm_pixel_mem_responder.sv
// Captures one test vector and replays it NUM_OF_SV times as a valid/ready stream.
// Define SVM_PARITY_EN to store an even-parity bit per pixel and flag bad beats on rd_perr.
module svm_pixel_mem_responder
    import svm_pkg::*;
#(
    parameter  int XLEN_PIXEL    = XLEN_PIXEL_DEF,
    parameter  int NUM_OF_PIXELS = 784,
    parameter  int NUM_OF_SV     = 10,
    localparam int PIX_W         = idx_w(NUM_OF_PIXELS),
    localparam int SV_W          = idx_w(NUM_OF_SV)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic                  wr_valid,
    input  logic [XLEN_PIXEL-1:0] wr_data,
    output logic                  load_done,
    output logic                  ovf_err,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [XLEN_PIXEL-1:0] rd_pixel,
    output logic [PIX_W-1:0]      rd_pix_idx,
    output logic [SV_W-1:0]       rd_sv_idx,
    output logic                  rd_last,
    output logic                  rd_done,
    output logic                  rd_perr
);

`ifdef SVM_PARITY_EN
    localparam int MEM_W = XLEN_PIXEL + 1;
`else
    localparam int MEM_W = XLEN_PIXEL;
`endif

    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NUM_OF_PIXELS - 1);
    localparam logic [SV_W-1:0]  LAST_SV  = SV_W'(NUM_OF_SV - 1);

    state_t           state;
    logic [PIX_W-1:0] wr_cnt, rd_pix, s1_pix, ram_addr;
    logic [SV_W-1:0]  rd_sv, s1_sv;
    logic             issue_done, s1_valid;
    logic [MEM_W-1:0] ram_wdata, ram_rdata;
    logic             wr_fire, out_ready, s1_adv, issue, perr;

    // Stage 1 is the RAM read register, stage 2 the output register; both stall together.
    assign wr_fire   = (state == LOAD) && we && wr_valid;
    assign out_ready = !rd_valid || rd_ready;
    assign s1_adv    = !s1_valid || out_ready;
    assign issue     = (state == STREAM) && !issue_done && s1_adv;
    assign ram_addr  = (state == LOAD) ? wr_cnt : rd_pix;

`ifdef SVM_PARITY_EN
    assign ram_wdata = {^wr_data, wr_data};
    assign perr      = ^ram_rdata;
`else
    assign ram_wdata = wr_data;
    assign perr      = 1'b0;
`endif

    svm_pixel_ram #(
        .WIDTH (MEM_W),
        .DEPTH (NUM_OF_PIXELS)
    ) u_ram (
        .clk   (clk),
        .en    (s1_adv),
        .we    (wr_fire),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // NOTE: every register below uses <= so all flops sample pre-edge values in parallel.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            wr_cnt    <= '0;
            load_done <= 1'b0;
            ovf_err   <= 1'b0;
        end else begin
            if (state != LOAD && we && wr_valid) ovf_err <= 1'b1;
            case (state)
                LOAD: begin
                    if (wr_fire) begin
                        wr_cnt <= wr_cnt + 1'b1;
                        if (wr_cnt == LAST_PIX) begin
                            state     <= FULL;
                            load_done <= 1'b1;
                        end
                    end
                end
                FULL:   if (re) state <= STREAM;
                STREAM: if (rd_valid && rd_ready && rd_done) state <= DONE;
                DONE: begin
                    if (we && !re) begin
                        state     <= LOAD;
                        wr_cnt    <= '0;
                        load_done <= 1'b0;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pix     <= '0;
            rd_sv      <= '0;
            issue_done <= 1'b0;
            s1_valid   <= 1'b0;
            s1_pix     <= '0;
            s1_sv      <= '0;
            rd_valid   <= 1'b0;
            rd_pixel   <= '0;
            rd_pix_idx <= '0;
            rd_sv_idx  <= '0;
            rd_last    <= 1'b0;
            rd_done    <= 1'b0;
            rd_perr    <= 1'b0;
        end else begin
            if (state == FULL) begin
                rd_pix     <= '0;
                rd_sv      <= '0;
                issue_done <= 1'b0;
            end else if (issue) begin
                if (rd_pix == LAST_PIX) begin
                    rd_pix <= '0;
                    if (rd_sv == LAST_SV) issue_done <= 1'b1;
                    else                  rd_sv      <= rd_sv + 1'b1;
                end else begin
                    rd_pix <= rd_pix + 1'b1;
                end
            end

            if (s1_adv) begin
                s1_valid <= issue;
                s1_pix   <= rd_pix;
                s1_sv    <= rd_sv;
            end

            if (out_ready) begin
                rd_valid   <= s1_valid;
                rd_pixel   <= ram_rdata[XLEN_PIXEL-1:0];
                rd_pix_idx <= s1_pix;
                rd_sv_idx  <= s1_sv;
                rd_last    <= s1_valid && (s1_pix == LAST_PIX);
                rd_done    <= s1_valid && (s1_pix == LAST_PIX) && (s1_sv == LAST_SV);
                rd_perr    <= s1_valid && perr;
            end
        end
    end

endmodule
